// File: rtl/lcd_spi_pkg.sv
// Shared constants and decoder state type for the LCD SPI receiver.
package lcd_spi_pkg;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CASET,
    ST_RASET,
    ST_RAMWR
  } dec_state_t;

  function automatic dec_state_t cmd_to_state(input logic [7:0] cmd);
    case (cmd)
      CMD_CASET: return ST_CASET;
      CMD_RASET: return ST_RASET;
      CMD_RAMWR: return ST_RAMWR;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/lcd_spi_deser.sv
// Oversampling SPI mode-0 deserialiser: synchronisers, sclk edge detect,
// MSB-first shift register, byte strobe and partial-byte framing error.
module lcd_spi_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  input  logic       spi_dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       frame_err
);

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, dc_sync, cs_sync;
  logic       sclk_prev, cs_prev;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic [7:0] shift_q;
  logic       dc_lat, done_q;
  logic       sclk_s, cs_s, sample, cs_rise;

  // NOTE: the cs_n chain resets to 1 (deselected) so leaving reset never looks like a select edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      dc_sync   <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], spi_dc};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign cs_rise = cs_s & ~cs_prev;
  // A bit arriving in the same cycle as the deselect edge still counts.
  assign sample  = sclk_s & ~sclk_prev & (~cs_s | ~cs_prev);
  assign bit_cnt_next = sample ? bit_cnt + 3'd1 : bit_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= '0;
      shift_q    <= '0;
      dc_lat     <= 1'b0;
      done_q     <= 1'b0;
      frame_err  <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      byte_dc    <= 1'b0;
    end else begin
      if (sample) shift_q <= {shift_q[6:0], mosi_sync[SYNC_STAGES-1]};
      if (sample && bit_cnt == 3'd7) dc_lat <= dc_sync[SYNC_STAGES-1];
      done_q     <= sample && (bit_cnt == 3'd7);
      frame_err  <= cs_rise && (bit_cnt_next != 3'd0);
      bit_cnt    <= cs_rise ? 3'd0 : bit_cnt_next;
      byte_valid <= done_q;
      if (done_q) begin
        byte_data <= shift_q;
        byte_dc   <= dc_lat;
      end
    end
  end

endmodule

// File: rtl/lcd_spi_receiver.sv
// LCD SPI responder: byte deserialiser plus CASET/RASET/RAMWR decoder that
// turns the RAMWR stream into addressed RGB565 pixels.
module lcd_spi_receiver
  import lcd_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int H_RES       = 240,
  parameter int V_RES       = 240,
  parameter int COORD_W     = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_sclk,
  input  logic               spi_mosi,
  input  logic               spi_cs_n,
  input  logic               spi_dc,
  output logic               byte_valid,
  output logic [7:0]         byte_data,
  output logic               byte_dc,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [15:0]        pix_rgb565,
  output logic               frame_err
);

  localparam logic [COORD_W-1:0] XE_RST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] YE_RST = COORD_W'(V_RES - 1);

  lcd_spi_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .spi_dc     (spi_dc),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .frame_err  (frame_err)
  );

  dec_state_t         state_q, state_d;
  logic [1:0]         idx_q;
  logic [15:0]        s_buf_q;
  logic [7:0]         e_hi_q, hold_q;
  logic               half_q;
  logic [COORD_W-1:0] xs_q, xe_q, ys_q, ye_q, x_q, y_q;
  logic               cmd_in, param_in, win_load, pix_in, pix_fire, ramwr_enter;
  logic [COORD_W-1:0] s_new, e_new, e_fix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (byte_valid) begin
      if (!byte_dc) state_d = cmd_to_state(byte_data);
      else if ((state_q == ST_CASET || state_q == ST_RASET) && idx_q == 2'd3) state_d = ST_IDLE;
    end
  end

  // NOTE: every strobe gets a value on every path, so no latch can be inferred here.
  always_comb begin
    cmd_in      = byte_valid & ~byte_dc;
    param_in    = byte_valid & byte_dc & (state_q == ST_CASET || state_q == ST_RASET);
    win_load    = param_in & (idx_q == 2'd3);
    pix_in      = byte_valid & byte_dc & (state_q == ST_RAMWR);
    pix_fire    = pix_in & half_q;
    ramwr_enter = cmd_in & (byte_data == CMD_RAMWR);
    s_new       = COORD_W'(s_buf_q);
    e_new       = COORD_W'({e_hi_q, byte_data});
    e_fix       = (e_new < s_new) ? s_new : e_new;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      s_buf_q    <= '0;
      e_hi_q     <= '0;
      hold_q     <= '0;
      half_q     <= 1'b0;
      xs_q       <= '0;
      xe_q       <= XE_RST;
      ys_q       <= '0;
      ye_q       <= YE_RST;
      x_q        <= '0;
      y_q        <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb565 <= '0;
    end else begin
      // A new command discards any half-collected parameter set.
      if (cmd_in) idx_q <= 2'd0;
      else if (param_in) begin
        case (idx_q)
          2'd0:    s_buf_q[15:8] <= byte_data;
          2'd1:    s_buf_q[7:0]  <= byte_data;
          2'd2:    e_hi_q        <= byte_data;
          default: ;
        endcase
        idx_q <= idx_q + 2'd1;
      end

      if (win_load) begin
        if (state_q == ST_CASET) begin
          xs_q <= s_new;
          xe_q <= e_fix;
        end else begin
          ys_q <= s_new;
          ye_q <= e_fix;
        end
      end

      if (ramwr_enter) begin
        x_q    <= xs_q;
        y_q    <= ys_q;
        half_q <= 1'b0;
      end else if (pix_in) begin
        half_q <= ~half_q;
        if (!half_q) hold_q <= byte_data;
        else if (x_q == xe_q) begin
          x_q <= xs_q;
          y_q <= (y_q == ye_q) ? ys_q : y_q + COORD_W'(1);
        end else begin
          x_q <= x_q + COORD_W'(1);
        end
      end

      pix_valid <= pix_fire;
      if (pix_fire) begin
        pix_x      <= x_q;
        pix_y      <= y_q;
        pix_rgb565 <= {hold_q, byte_data};
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_receiver.sv
// Scoreboard bench: stimulus pushes expected bytes/pixels/errors, a monitor pops on DUT strobes.
module tb_lcd_spi_receiver;

  localparam int COORD_W = 9;

  logic               clk = 1'b0;
  logic               rst_n, spi_sclk, spi_mosi, spi_cs_n, spi_dc;
  logic               byte_valid, byte_dc, pix_valid, frame_err;
  logic [7:0]         byte_data;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic [15:0]        pix_rgb565;

  typedef struct { logic dc; logic [7:0] data; } byte_exp_t;
  typedef struct { int x; int y; logic [15:0] rgb; } pix_exp_t;

  byte_exp_t byte_q[$];
  pix_exp_t  pix_q[$];
  int        exp_ferr = 0;
  int        total = 0;
  int        bad = 0;

  lcd_spi_receiver #(.SYNC_STAGES(2), .H_RES(240), .V_RES(240), .COORD_W(COORD_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .spi_dc     (spi_dc),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_dc    (byte_dc),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_rgb565 (pix_rgb565),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " byte_valid"}, 32'(byte_valid), 0);
    check({tag, " byte_data"},  32'(byte_data), 0);
    check({tag, " byte_dc"},    32'(byte_dc), 0);
    check({tag, " pix_valid"},  32'(pix_valid), 0);
    check({tag, " pix_x"},      32'(pix_x), 0);
    check({tag, " pix_y"},      32'(pix_y), 0);
    check({tag, " pix_rgb565"}, 32'(pix_rgb565), 0);
    check({tag, " frame_err"},  32'(frame_err), 0);
  endtask

  // Monitor: every DUT strobe is matched against the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin
        if (byte_q.size() == 0) check("unexpected byte_valid", 32'(byte_data), 32'hFFFF_FFFF);
        else begin
          byte_exp_t e;
          e = byte_q.pop_front();
          check("byte_data", 32'(byte_data), 32'(e.data));
          check("byte_dc", 32'(byte_dc), 32'(e.dc));
        end
      end
      if (pix_valid) begin
        if (pix_q.size() == 0) check("unexpected pix_valid", 32'(pix_rgb565), 32'hFFFF_FFFF);
        else begin
          pix_exp_t p;
          p = pix_q.pop_front();
          check("pix_x", 32'(pix_x), 32'(p.x));
          check("pix_y", 32'(pix_y), 32'(p.y));
          check("pix_rgb565", 32'(pix_rgb565), 32'(p.rgb));
        end
      end
      if (frame_err) begin
        check("frame_err expected", 32'(exp_ferr > 0), 1);
        if (exp_ferr > 0) exp_ferr--;
      end
    end
  end

  task automatic spi_bits(input logic dc, input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      spi_dc   = dc;
      spi_mosi = b[i];
      #20 spi_sclk = 1'b1;
      #20 spi_sclk = 1'b0;
    end
  endtask

  task automatic send(input logic dc, input logic [7:0] b);
    byte_exp_t e;
    e.dc = dc;
    e.data = b;
    byte_q.push_back(e);
    spi_bits(dc, b, 8);
  endtask

  task automatic push_pix(input int x, input int y, input logic [15:0] rgb);
    pix_exp_t p;
    p.x = x;
    p.y = y;
    p.rgb = rgb;
    pix_q.push_back(p);
  endtask

  task automatic cs_lo();
    spi_cs_n = 1'b0;
    #20;
  endtask

  task automatic cs_hi();
    #20 spi_cs_n = 1'b1;
    #40;
  endtask

  task automatic send_framed(input logic dc, input logic [7:0] b);
    cs_lo();
    send(dc, b);
    cs_hi();
  endtask

  // Fixed drain window: anything still queued after it is a missing output.
  task automatic drain(input string tag);
    repeat (20) @(posedge clk);
    #2;
    check({tag, " bytes outstanding"}, byte_q.size(), 0);
    check({tag, " pixels outstanding"}, pix_q.size(), 0);
    check({tag, " frame_err outstanding"}, exp_ferr, 0);
  endtask

  initial begin
    logic [15:0] rgb;
    rst_n = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; spi_dc = 1'b0;
    #23;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #2;

    // Partial CASET abandoned by RAMWR: default window, start at (0,0).
    cs_lo();
    send(1'b0, 8'h2A); send(1'b1, 8'h00); send(1'b1, 8'h10);
    send(1'b0, 8'h2C);
    push_pix(0, 0, 16'hABCD);
    send(1'b1, 8'hAB); send(1'b1, 8'hCD);
    cs_hi();
    drain("partial_caset");

    // Full default row then the wrap to the next row.
    cs_lo();
    send(1'b0, 8'h2C);
    for (int i = 0; i < 241; i++) begin
      rgb = {8'(i), ~8'(i)};
      push_pix((i < 240) ? i : 0, (i < 240) ? 0 : 1, rgb);
      send(1'b1, rgb[15:8]);
      send(1'b1, rgb[7:0]);
    end
    cs_hi();
    drain("row_wrap");

    // CASET with per-byte chip select, then RASET and a 3-pixel RAMWR.
    send_framed(1'b0, 8'h2A);
    send_framed(1'b1, 8'h00); send_framed(1'b1, 8'h0A);
    send_framed(1'b1, 8'h00); send_framed(1'b1, 8'h0B);
    cs_lo();
    send(1'b0, 8'h2B); send(1'b1, 8'h00); send(1'b1, 8'h05); send(1'b1, 8'h00); send(1'b1, 8'h05);
    send(1'b0, 8'h2C);
    push_pix(10, 5, 16'hF800); push_pix(11, 5, 16'h07E0); push_pix(10, 5, 16'h001F);
    send(1'b1, 8'hF8); send(1'b1, 8'h00); send(1'b1, 8'h07);
    send(1'b1, 8'hE0); send(1'b1, 8'h00); send(1'b1, 8'h1F);
    cs_hi();
    drain("window");

    // Deselect after 5 bits: error pulse, partial byte dropped, next byte aligned.
    cs_lo();
    exp_ferr++;
    spi_bits(1'b1, 8'hFF, 5);
    cs_hi();
    cs_lo();
    send(1'b0, 8'h00);
    send(1'b1, 8'h5A);
    cs_hi();
    drain("frame_err");

    // Asynchronous reset after the first RAMWR byte.
    cs_lo();
    send(1'b0, 8'h2C);
    send(1'b1, 8'h12);
    cs_hi();
    drain("pre_reset");
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    cs_lo();
    send(1'b1, 8'h34);
    send(1'b1, 8'h56);
    cs_hi();
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
